bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It succeeds the fixed 8-bit serial converter and adds configurable binary width, configurable BCD digit count, a start/busy/valid handshake, and overflow detection when the digit count cannot hold the value. It sits between binary datapath results and decimal display or formatting logic.

## Interface
- BIN_WIDTH, 8: binary input width in bits, at least 2.
- DIGITS, 3: number of BCD digits produced, at least 1; BCD output width is 4*DIGITS.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request a conversion; sampled only when busy_o=0.
- bin_i  input  BIN_WIDTH  unsigned binary operand; captured on the accepted start edge.
- busy_o  output  1  high while a conversion is in progress.
- valid_o  output  1  one-cycle pulse when bcd_o and overflow_o are updated.
- bcd_o  output  4*DIGITS  packed BCD result, most significant digit in the top nibble; held between conversions.
- overflow_o  output  1  high when bin_i exceeds 10^DIGITS-1; updated together with bcd_o.

## Operation
- FSM states:
  - IDLE: busy_o=0.
  - SHIFT: busy_o=1, runs BIN_WIDTH iterations; bit counter counts 0..BIN_WIDTH-1.
- IDLE->SHIFT: start_i=1 on a clock edge.
  - Captures bin_i into the shift register.
  - Clears the BCD work register and the sticky overflow bit.
  - Clears the bit counter.
- Each SHIFT cycle:
  - For every work digit, add 3 if the digit is 5 or more. All digits are corrected in parallel, from pre-shift values.
  - Shift {work, shift register} left by one, bringing in the shift register MSB.
  - The bit leaving the top of the top digit ORs into the sticky overflow bit.
- SHIFT->IDLE: on the iteration with counter = BIN_WIDTH-1.
  - Loads the final work register into bcd_o and the sticky bit into overflow_o.
  - Pulses valid_o.
- When overflow occurs, bcd_o holds the low DIGITS decimal digits of the value (truncated modulo 10^DIGITS).
- start_i is ignored while busy_o=1; there is no queueing. bin_i matters only on the accepted edge.
- Reset (asynchronous, at any time including mid-conversion): abort and enter IDLE.
  - busy_o=0, valid_o=0, overflow_o=0, bcd_o=0.
  - Work, shift and counter registers cleared.
  - No valid_o is issued for the aborted conversion.
- Arithmetic is unsigned only. Each digit stays in 0..9 after correction and shift when not overflowing.

## Timing
- Edge 0: start accepted; busy_o=1 from edge 0.
- Edges 1..BIN_WIDTH: the BIN_WIDTH shift iterations.
- Edge BIN_WIDTH:
  - bcd_o and overflow_o update.
  - valid_o=1 for exactly one cycle.
  - busy_o=0.
- Latency from start to result: BIN_WIDTH cycles. The earliest next accepted start is edge BIN_WIDTH+1.
- Throughput: one conversion per BIN_WIDTH+1 cycles with start_i held high.
- A start_i asserted in the cycle where valid_o=1 is accepted (busy_o=0 then). The new result does not disturb bcd_o until its own valid_o.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Defaults, bin_i=0, 99, 200, 255:
  - bcd_o = 0x000, 0x099, 0x200, 0x255 respectively.
  - overflow_o=0.
  - valid_o exactly 8 cycles after the start edge, one cycle wide.
- Defaults, start_i held high, bin_i cycled 1, 128, 254:
  - Results 0x001, 0x128, 0x254 on consecutive valid_o pulses spaced 9 cycles apart.
  - busy_o low for one cycle between conversions.
- Defaults, start_i pulsed at cycles 3 and 5 of a running conversion with bin_i=77:
  - Pulses ignored; only the original operand's result appears.
  - No extra valid_o.
- BIN_WIDTH=8, DIGITS=2:
  - bin_i=99 -> bcd_o=0x99, overflow_o=0.
  - bin_i=100 -> 0x00, overflow_o=1.
  - bin_i=255 -> 0x55, overflow_o=1.
- BIN_WIDTH=16, DIGITS=5:
  - bin_i=65535 -> bcd_o=0x65535.
  - bin_i=10000 -> 0x10000.
  - valid_o after 16 cycles.
- Defaults, rst_i pulsed asynchronously mid-conversion (between clock edges, iteration 4):
  - All outputs 0 immediately; no valid_o.
  - A new start after release converts 42 -> 0x042 correctly.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Parametrised widths, start/busy/valid handshake, sticky overflow when DIGITS is too small.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [BIN_WIDTH-1:0]   bin_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [4*DIGITS-1:0]    bcd_o,
  output logic                   overflow_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [BCD_W-1:0]       bcd_q;
  logic                   overflow_q;
  logic [BCD_W-1:0]       work_q;
  logic [BIN_WIDTH-1:0]   shift_q;
  logic                   sticky_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [BCD_W-1:0]       adj_s;
  logic                   carry_s;
  logic [BCD_W-1:0]       work_d;
  logic [BIN_WIDTH-1:0]   shift_d;
  logic                   sticky_d;

  function automatic logic [3:0] dabble_digit(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  // One double-dabble iteration: correct all digits from pre-shift values, then shift left.
  always_comb begin
    adj_s = {BCD_W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = dabble_digit(work_q[4*i +: 4]);
    end
    {carry_s, work_d} = {adj_s, shift_q[BIN_WIDTH-1]};
    shift_d  = {shift_q[BIN_WIDTH-2:0], 1'b0};
    // A bit carried out of the top digit means the value no longer fits in DIGITS digits.
    sticky_d = sticky_q | carry_s;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      bcd_q      <= {BCD_W{1'b0}};
      overflow_q <= 1'b0;
      work_q     <= {BCD_W{1'b0}};
      shift_q    <= {BIN_WIDTH{1'b0}};
      sticky_q   <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            state_q  <= ST_SHIFT;
            busy_q   <= 1'b1;
            shift_q  <= bin_i;
            work_q   <= {BCD_W{1'b0}};
            sticky_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          work_q   <= work_d;
          shift_q  <= shift_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            valid_q    <= 1'b1;
            bcd_q      <= work_d;
            overflow_q <= sticky_d;
          end else begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign bcd_o      = bcd_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: defaults (8b/3d), narrow (8b/2d) and wide (16b/5d) instances.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  bin_a = 8'd0, bin_b = 8'd0;
  logic [15:0] bin_c = 16'd0;
  logic        busy_a, busy_b, busy_c, valid_a, valid_b, valid_c, ovf_a, ovf_b, ovf_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;

  int checks = 0;
  int failures = 0;

  bin2bcd_seq dut_a (.clk_i(clk), .rst_i(rst), .start_i(start_a), .bin_i(bin_a),
                     .busy_o(busy_a), .valid_o(valid_a), .bcd_o(bcd_a), .overflow_o(ovf_a));
  bin2bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut_b (.clk_i(clk), .rst_i(rst), .start_i(start_b),
                     .bin_i(bin_b), .busy_o(busy_b), .valid_o(valid_b), .bcd_o(bcd_b), .overflow_o(ovf_b));
  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut_c (.clk_i(clk), .rst_i(rst), .start_i(start_c),
                     .bin_i(bin_c), .busy_o(busy_c), .valid_o(valid_c), .bcd_o(bcd_c), .overflow_o(ovf_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int sel, output logic v, output logic b,
                        output logic [19:0] bcd, output logic o);
    case (sel)
      0: begin v = valid_a; b = busy_a; bcd = {8'd0, bcd_a}; o = ovf_a; end
      1: begin v = valid_b; b = busy_b; bcd = {12'd0, bcd_b}; o = ovf_b; end
      default: begin v = valid_c; b = busy_c; bcd = bcd_c; o = ovf_c; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic s, input logic [15:0] bin);
    case (sel)
      0: begin start_a = s; bin_a = bin[7:0]; end
      1: begin start_b = s; bin_b = bin[7:0]; end
      default: begin start_c = s; bin_c = bin; end
    endcase
  endtask

  // Single conversion; checks busy, latency, pulse width and result.
  task automatic run_conv(input int sel, input logic [15:0] bin, input logic [19:0] exp_bcd,
                          input logic exp_ovf, input int lat, input string tag);
    logic v, b, o;
    logic [19:0] bcd;
    int first_v = -1;
    int nv = 0;
    @(negedge clk);
    set_start(sel, 1'b1, bin);
    @(posedge clk); #1;
    set_start(sel, 1'b0, bin);
    sample(sel, v, b, bcd, o);
    chk({tag, "_busy0"}, {31'd0, b}, 32'd1);
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk); #1;
      sample(sel, v, b, bcd, o);
      if (v) begin
        nv++;
        if (first_v < 0) first_v = k;
      end
      if (k == lat) begin
        chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
        chk({tag, "_ovf"}, {31'd0, o}, {31'd0, exp_ovf});
        chk({tag, "_busy_end"}, {31'd0, b}, 32'd0);
      end
    end
    chk({tag, "_lat"}, first_v, lat);
    chk({tag, "_nvalid"}, nv, 32'd1);
  endtask

  int vcnt;
  int vedge[3];
  logic [11:0] vbcd[3];
  int busy_low;

  initial begin
    #12;
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
    chk("rst_bcd_a", {20'd0, bcd_a}, 32'd0);
    chk("rst_ovf_a", {31'd0, ovf_a}, 32'd0);
    chk("rst_bcd_c", {12'd0, bcd_c}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_conv(0, 16'd0,   20'h00000, 1'b0, 8, "a0");
    run_conv(0, 16'd99,  20'h00099, 1'b0, 8, "a99");
    run_conv(0, 16'd200, 20'h00200, 1'b0, 8, "a200");
    run_conv(0, 16'd255, 20'h00255, 1'b0, 8, "a255");

    run_conv(1, 16'd99,  20'h00099, 1'b0, 8, "b99");
    run_conv(1, 16'd100, 20'h00000, 1'b1, 8, "b100");
    run_conv(1, 16'd255, 20'h00055, 1'b1, 8, "b255");
    run_conv(1, 16'd42,  20'h00042, 1'b0, 8, "b42_ovf_clears");

    run_conv(2, 16'd65535, 20'h65535, 1'b0, 16, "c65535");
    run_conv(2, 16'd10000, 20'h10000, 1'b0, 16, "c10000");

    // start held high, operand changed after each valid
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd1;
    @(posedge clk); #1;
    vcnt = 0; busy_low = 0;
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk); #1;
      if (valid_a) begin
        if (vcnt < 3) begin vedge[vcnt] = e; vbcd[vcnt] = bcd_a; end
        vcnt++;
      end
      if (!busy_a && e <= 26) busy_low++;
      if (e == 8)  bin_a = 8'd128;
      if (e == 17) bin_a = 8'd254;
      if (e == 26) start_a = 1'b0;
    end
    chk("hold_nvalid", vcnt, 32'd3);
    chk("hold_e0", vedge[0], 32'd8);
    chk("hold_e1", vedge[1], 32'd17);
    chk("hold_e2", vedge[2], 32'd26);
    chk("hold_r0", {20'd0, vbcd[0]}, 32'h001);
    chk("hold_r1", {20'd0, vbcd[1]}, 32'h128);
    chk("hold_r2", {20'd0, vbcd[2]}, 32'h254);
    chk("hold_busy_low", busy_low, 32'd3);

    // starts during a running conversion must be ignored
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd77;
    @(posedge clk); #1;
    start_a = 1'b0; bin_a = 8'd200;
    vcnt = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 3 || e == 5) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (valid_a) begin
        vcnt++;
        chk("ign_bcd", {20'd0, bcd_a}, 32'h077);
        chk("ign_edge", e, 32'd8);
      end
      if (e >= 9) chk("ign_idle", {31'd0, busy_a}, 32'd0);
    end
    chk("ign_nvalid", vcnt, 32'd1);

    // asynchronous reset between edges during iteration 4
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd200;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_a}, 32'd0);
    chk("arst_valid", {31'd0, valid_a}, 32'd0);
    chk("arst_bcd", {20'd0, bcd_a}, 32'd0);
    chk("arst_ovf", {31'd0, ovf_a}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (valid_a) vcnt++;
    end
    chk("arst_novalid", vcnt, 32'd0);
    run_conv(0, 16'd42, 20'h00042, 1'b0, 8, "arst_a42");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
